// File: rtl/mont_const_unit_if.sv
// Request/response bundle between the Montgomery constant unit and its user.
// Latency: n/a (wires only).
// Backpressure: none; en is the only way to hold the unit, done is a pulse.
// Signals:
//   en     global enable, 0 freezes the unit
//   start  request a computation (sampled only while idle)
//   M      modulus, latched when start is accepted
//   busy   computation in progress
//   done   one-cycle result strobe (stretched while en=0)
//   err    modulus unusable for Montgomery multiplication
//   Const  result 2^(2*R_EXP) mod M
interface mont_const_unit_if #(
  parameter int N_BITS = 8
);
  logic              en;
  logic              start;
  logic [N_BITS-1:0] M;
  logic              busy;
  logic              done;
  logic              err;
  logic [N_BITS-1:0] Const;

  // requester side
  modport master (
    output en, start, M,
    input  busy, done, err, Const
  );

  // constant unit side
  modport slave (
    input  en, start, M,
    output busy, done, err, Const
  );
endinterface

// File: rtl/mont_const_unit.sv
// Computes Const = 2^(2*R_EXP) mod M by repeated doubling with conditional subtract.
// Latency: 2*R_EXP RUN cycles after accepting start; invalid M reaches DONE directly.
// Backpressure: en=0 freezes everything (a stall in DONE stretches done); start ignored unless idle.
// Ports: clk, rstb (sync active-low) plain; bus (slave modport) carries en/start/M in and
//        busy/done/err/Const out.
module mont_const_unit #(
  parameter int N_BITS = 8,
  parameter int R_EXP  = 10
) (
  input  logic               clk,
  input  logic               rstb,
  mont_const_unit_if.slave   bus
);

  localparam int STEPS = 2 * R_EXP;
  localparam int CNT_W = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [N_BITS-1:0] r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] m_q, m_d;
  logic [N_BITS-1:0] const_q, const_d;
  logic              err_q, err_d;

  // One doubling step. r < m_q always holds, so t < 2*m_q and a single
  // subtract brings it back into range; the result always fits N_BITS.
  logic [N_BITS:0]   t;
  logic [N_BITS:0]   m_ext;
  logic [N_BITS-1:0] r_step;

  always_comb begin
    t      = {r_q, 1'b0};
    m_ext  = {1'b0, m_q};
    r_step = N_BITS'((t >= m_ext) ? (t - m_ext) : t);
  end

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    m_d     = m_q;
    const_d = const_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d   = bus.M;
          err_d = 1'b0;
          // Even or tiny moduli have no inverse mod 2^R_EXP; report and skip the loop.
          if (!bus.M[0] || (bus.M < N_BITS'(3))) begin
            err_d   = 1'b1;
            const_d = '0;
            state_d = DONE;
          end else begin
            r_d     = N_BITS'(1);
            cnt_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        r_d   = r_step;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          const_d = r_step;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      state_q <= IDLE;
      r_q     <= '0;
      cnt_q   <= '0;
      m_q     <= '0;
      const_q <= '0;
      err_q   <= 1'b0;
    end else if (bus.en) begin
      state_q <= state_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      m_q     <= m_d;
      const_q <= const_d;
      err_q   <= err_d;
    end
  end

  assign bus.busy  = (state_q == RUN);
  assign bus.done  = (state_q == DONE);
  assign bus.err   = err_q;
  assign bus.Const = const_q;

endmodule

// File: tb/tb_mont_const_unit.sv
module tb_mont_const_unit;

  localparam int NB    = 8;
  localparam int REXP  = 10;
  localparam int LAT   = 2 * REXP;
  localparam int LIMIT = 200;

  logic clk;
  logic rstb;
  int   checks;
  int   errors;

  mont_const_unit_if #(.N_BITS(NB)) bus ();

  mont_const_unit #(.N_BITS(NB), .R_EXP(REXP)) dut (
    .clk  (clk),
    .rstb (rstb),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: Const = 2^(2*REXP) mod M, or 0 with err for unusable moduli.
  function automatic logic [NB-1:0] model_const(input int m);
    longint p;
    if (m < 3 || (m % 2) == 0) return '0;
    p = longint'(1) << (2 * REXP);
    return NB'(p % m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulses start with modulus m, scrambles M afterwards, and returns once done is seen.
  task automatic run_one(input logic [NB-1:0] m, output int lat, output int busy_n,
                         output logic err_acc);
    bus.start = 1'b1;
    bus.M     = m;
    tick();
    bus.start = 1'b0;
    bus.M     = NB'($urandom);
    err_acc   = bus.err;
    lat       = 0;
    busy_n    = 0;
    while (!bus.done && lat < LIMIT) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    tick();
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", bus.err); end
    checks++; if (bus.Const !== 8'd0) begin errors++; $display("FAIL reset_const got %0d want 0", bus.Const); end
    rstb = 1'b1;
    tick();
  endtask

  task automatic test_known();
    int          lat, busy_n;
    logic        err_acc;
    logic [NB-1:0] held;
    int          mods [4] = '{13, 251, 255, 3};
    int          exps [4] = '{9, 149, 16, 1};
    for (int i = 0; i < 4; i++) begin
      run_one(NB'(mods[i]), lat, busy_n, err_acc);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL known_latency M=%0d got %0d want %0d", mods[i], lat, LAT); end
      checks++; if (busy_n !== LAT) begin errors++; $display("FAIL known_busy M=%0d got %0d want %0d", mods[i], busy_n, LAT); end
      checks++; if (bus.Const !== NB'(exps[i])) begin errors++; $display("FAIL known_const M=%0d got %0d want %0d", mods[i], bus.Const, exps[i]); end
      checks++; if (bus.Const !== model_const(mods[i])) begin errors++; $display("FAIL known_model M=%0d got %0d want %0d", mods[i], bus.Const, model_const(mods[i])); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL known_err M=%0d got %b want 0", mods[i], bus.err); end
      held = bus.Const;
      tick();
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL known_pulse M=%0d done got %b want 0", mods[i], bus.done); end
      checks++; if (bus.Const !== held) begin errors++; $display("FAIL known_hold M=%0d got %0d want %0d", mods[i], bus.Const, held); end
    end
  endtask

  task automatic test_invalid();
    int   lat, busy_n;
    logic err_acc;
    int   bad [4] = '{8, 1, 0, 2};
    for (int i = 0; i < 4; i++) begin
      run_one(NB'(bad[i]), lat, busy_n, err_acc);
      checks++; if (lat !== 0) begin errors++; $display("FAIL invalid_latency M=%0d got %0d want 0", bad[i], lat); end
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL invalid_err M=%0d got %b want 1", bad[i], bus.err); end
      checks++; if (bus.Const !== 8'd0) begin errors++; $display("FAIL invalid_const M=%0d got %0d want 0", bad[i], bus.Const); end
      tick();
      checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL invalid_err_held M=%0d got %b want 1", bad[i], bus.err); end
    end
    run_one(8'd13, lat, busy_n, err_acc);
    checks++; if (err_acc !== 1'b0) begin errors++; $display("FAIL invalid_err_clear got %b want 0", err_acc); end
    checks++; if (bus.Const !== 8'd9) begin errors++; $display("FAIL invalid_recover got %0d want 9", bus.Const); end
    tick();
  endtask

  task automatic test_stall();
    int n;
    bus.start = 1'b1;
    bus.M     = 8'd13;
    tick();
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 7; i++) begin tick(); n++; end
    bus.en = 1'b0;
    // Stalled start with a different modulus must have no effect.
    bus.start = 1'b1;
    bus.M     = 8'd7;
    for (int i = 0; i < 5; i++) begin tick(); n++; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b want 1", bus.busy); end
    bus.en = 1'b1;
    tick(); n++;
    bus.start = 1'b0;
    while (!bus.done && n < LIMIT) begin tick(); n++; end
    checks++; if (n !== LAT + 5) begin errors++; $display("FAIL stall_latency got %0d want %0d", n, LAT + 5); end
    checks++; if (bus.Const !== 8'd9) begin errors++; $display("FAIL stall_const got %0d want 9", bus.Const); end
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL stall_done_stretch got %b want 1", bus.done); end
    bus.en = 1'b1;
    tick();
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL stall_done_drop got %b want 0", bus.done); end
  endtask

  task automatic test_reset_mid();
    int seen;
    bus.start = 1'b1;
    bus.M     = 8'd13;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rstb = 1'b0;
    tick();
    rstb = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midreset_done got %b want 0", bus.done); end
    checks++; if (bus.Const !== 8'd0) begin errors++; $display("FAIL midreset_const got %0d want 0", bus.Const); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL midreset_err got %b want 0", bus.err); end
    seen = 0;
    for (int i = 0; i < 2 * LAT; i++) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midreset_no_done got %0d active cycles want 0", seen); end
  endtask

  task automatic test_back_to_back();
    int n;
    bus.start = 1'b1;
    bus.M     = 8'd251;
    tick();
    n = 0;
    while (!bus.done && n < LIMIT) begin tick(); n++; end
    checks++; if (n !== LAT) begin errors++; $display("FAIL b2b_first_latency got %0d want %0d", n, LAT); end
    checks++; if (bus.Const !== 8'd149) begin errors++; $display("FAIL b2b_first_const got %0d want 149", bus.Const); end
    bus.M = 8'd255;
    tick();
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin errors++; $display("FAIL b2b_idle busy=%b done=%b want 0 0", bus.busy, bus.done); end
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger got %b want 1", bus.busy); end
    n = 0;
    while (!bus.done && n < LIMIT) begin tick(); n++; end
    checks++; if (n !== LAT) begin errors++; $display("FAIL b2b_second_latency got %0d want %0d", n, LAT); end
    checks++; if (bus.Const !== 8'd16) begin errors++; $display("FAIL b2b_second_const got %0d want 16", bus.Const); end
    tick();
  endtask

  task automatic test_random();
    int   lat, busy_n, m;
    logic err_acc;
    for (int i = 0; i < 24; i++) begin
      m = 2 * int'($urandom_range(1, 127)) + 1;
      run_one(NB'(m), lat, busy_n, err_acc);
      checks++; if (lat !== LAT) begin errors++; $display("FAIL random_latency M=%0d got %0d want %0d", m, lat, LAT); end
      checks++; if (bus.Const !== model_const(m)) begin errors++; $display("FAIL random_const M=%0d got %0d want %0d", m, bus.Const, model_const(m)); end
      checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL random_err M=%0d got %b want 0", m, bus.err); end
      tick();
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rstb      = 1'b0;
    bus.en    = 1'b1;
    bus.start = 1'b0;
    bus.M     = '0;
    test_reset();
    test_known();
    test_invalid();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
